// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-pipeline constants: default widths, HLT encoding, fetch state encoding
// and the word-address wrap helper.
package instruction_fetch_unit_pkg;

  localparam int          IFU_ADDR_W    = 10;
  localparam int          IFU_DATA_W    = 32;
  localparam logic [31:0] IFU_HALT_WORD = 32'h0000_0000;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Increment a word address and wrap it to a 'width'-bit address space.
  function automatic logic [31:0] addr_wrap_inc(input logic [31:0] addr,
                                                input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Requester side of a synchronous-read instruction memory: generates the fetch address,
// pairs the returned word with its PC, and handles stall, redirect and HLT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = IFU_ADDR_W,
  parameter int                DATA_W     = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(IFU_HALT_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_next,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              accept;
  logic              hlt_seen;

  assign addr_inc   = ADDR_W'(addr_wrap_inc(32'(cur_addr), ADDR_W));
  assign if_valid   = (state == ST_RUN);
  assign halted     = (state == ST_HALTED);
  assign if_instr   = if_valid ? mem_data : '0;
  assign if_pc      = cur_addr;
  assign if_pc_next = addr_inc;
  assign accept     = if_valid && !stall;
  assign hlt_seen   = accept && !redirect && (mem_data == HALT_WORD);

  // Reset pins the address so the memory sees RESET_ADDR even if a redirect is pending.
  always_comb begin
    mem_addr = addr_inc;
    if (reset)                  mem_addr = RESET_ADDR;
    else if (redirect)          mem_addr = redirect_addr;
    else if (state == ST_FILL)  mem_addr = RESET_ADDR;
    else if (state == ST_HALTED || stall) mem_addr = cur_addr;
  end

  always_comb begin
    state_nxt = ST_FILL;
    case (state)
      ST_FILL:   state_nxt = ST_RUN;
      ST_RUN:    state_nxt = hlt_seen ? ST_HALTED : ST_RUN;
      ST_HALTED: state_nxt = redirect ? ST_RUN : ST_HALTED;
      default:   state_nxt = ST_FILL;
    endcase
  end

  // cur_addr mirrors the address the memory latched, so mem_data is always rom[cur_addr].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FILL;
      cur_addr <= RESET_ADDR;
    end else begin
      state    <= state_nxt;
      cur_addr <= mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan steps followed by randomized
// stall/redirect traffic, checked against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_next;
  logic          if_valid;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [DW-1:0] rom [DEPTH];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_mode;   // 0: waiting for first word, 1: fetching, 2: stopped on HLT
  int          m_pc;     // address of the word on the IF/ID outputs
  int unsigned m_count;  // words handed to decode

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_next    (if_pc_next),
    .if_valid      (if_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address the fetch unit should present this cycle, from the behavioural rules.
  function automatic int model_next(input logic st, input logic rd, input int ra);
    if (rd) return ra;
    if (m_mode == 0) return 0;
    if (m_mode == 2 || st) return m_pc;
    return (m_pc + 1) % DEPTH;
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    int nxt;
    bit v;
    @(negedge clk);
    v = (m_mode == 1);
    check("if_valid",    32'(if_valid),   32'(v));
    check("halted",      32'(halted),     32'(m_mode == 2));
    check("if_pc",       32'(if_pc),      m_pc);
    check("if_pc_next",  32'(if_pc_next), (m_pc + 1) % DEPTH);
    check("if_instr",    if_instr,        v ? rom[m_pc] : 32'd0);
    nxt = model_next(stall, redirect, int'(redirect_addr));
    check("mem_addr",    32'(mem_addr),   nxt);
    check("fetch_count", fetch_count,     m_count);
    @(posedge clk);
    if (v && !stall) m_count++;
    case (m_mode)
      0: m_mode = 1;
      1: if (rom[m_pc] == 32'd0 && !stall && !redirect) m_mode = 2;
      2: if (redirect) m_mode = 1;
      default: m_mode = 0;
    endcase
    m_pc = nxt;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(if_valid),   32'd0);
    check({tag, "_halt"},  32'(halted),     32'd0);
    check({tag, "_instr"}, if_instr,        32'd0);
    check({tag, "_pc"},    32'(if_pc),      32'd0);
    check({tag, "_maddr"}, 32'(mem_addr),   32'd0);
    check({tag, "_cnt"},   fetch_count,     32'd0);
  endtask

  // Reset asserted between edges; optionally reload the ROM with random words.
  task automatic async_reset(input bit randomize_rom);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    stall = 1'b0;
    redirect = 1'b0;
    if (randomize_rom) begin
      for (int i = 0; i < DEPTH; i++)
        rom[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
    end
    m_mode  = 0;
    m_pc    = 0;
    m_count = 0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'd0;
    rom[0]    = 32'h2042_0020;
    rom[1]    = 32'h2063_0001;
    rom[2]    = 32'h0043_2006;
    rom[1023] = 32'hDEAD_BEEF;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    m_mode = 0;
    m_pc = 0;
    m_count = 0;
    #3;
    check_reset_values("por");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset release: FILL, words 0..2, HLT at 3, then halted
    for (int i = 0; i < 5; i++) step();
    check("hlt_halted", 32'(halted),   32'd1);
    check("hlt_maddr",  32'(mem_addr), 32'd4);
    check("hlt_count",  fetch_count,   32'd4);
    step();
    step();
    check("hlt_hold_maddr", 32'(mem_addr), 32'd4);

    // Redirect out of HALTED
    redirect = 1'b1;
    redirect_addr = 10'd1;
    step();
    redirect = 1'b0;
    check("unhalt_pc",    32'(if_pc),    32'd1);
    check("unhalt_valid", 32'(if_valid), 32'd1);
    check("unhalt_halt",  32'(halted),   32'd0);

    // Stall for two cycles at pc 1
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    check("stall_instr", if_instr, 32'h2063_0001);
    step();
    check("stall_pc_after", 32'(if_pc),   32'd2);
    check("stall_count",    fetch_count, 32'd5);

    // Redirect with no bubble
    redirect = 1'b1;
    redirect_addr = 10'd0;
    step();
    redirect = 1'b0;
    check("redir_pc",    32'(if_pc),    32'd0);
    check("redir_instr", if_instr,      32'h2042_0020);
    check("redir_valid", 32'(if_valid), 32'd1);

    // Wrap 1023 -> 0
    redirect = 1'b1;
    redirect_addr = 10'd1023;
    step();
    redirect = 1'b0;
    check("wrap_instr", if_instr, 32'hDEAD_BEEF);
    step();
    check("wrap_pc", 32'(if_pc), 32'd0);

    // Stall and redirect together: target wins
    stall = 1'b1;
    redirect = 1'b1;
    redirect_addr = 10'd2;
    step();
    stall = 1'b0;
    redirect = 1'b0;
    check("conflict_pc",    32'(if_pc),    32'd2);
    check("conflict_instr", if_instr,      32'h0043_2006);
    step();
    step();

    // Asynchronous reset mid-stream, restart through FILL
    async_reset(1'b0);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic over random ROM images
    for (int r = 0; r < 3; r++) begin
      async_reset(1'b1);
      for (int c = 0; c < 300; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        redirect = ($urandom_range(0, 6) == 0);
        redirect_addr = ($urandom_range(0, 9) == 0) ? 10'd1023 : AW'($urandom_range(0, DEPTH - 1));
        step();
      end
      stall = 1'b0;
      redirect = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Requester side of the synchronous-read instruction memory.
- Each cycle it generates the 10-bit word address (`direccion`) and pairs the returned 32-bit word (`instruccion`, valid the cycle after the address is sampled) with its PC.
- Applies hazard-unit stalls and branch/jump redirects, stops on the HLT word, and presents a qualified IF/ID payload to decode.

## Interface

Parameters:
- `ADDR_W`, 10: instruction word-address width; matches memory depth 1024.
- `DATA_W`, 32: instruction width.
- `RESET_ADDR`, 0: first word fetched after reset.
- `HALT_WORD`, 32'h00000000: encoding treated as HLT.

Ports:
- `clk`  in  1  rising-edge clock, shared with instruction memory.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  from HDU; decode cannot accept the current word.
- `redirect`  in  1  taken branch/jump resolved this cycle.
- `redirect_addr`  in  ADDR_W  target word address.
- `mem_addr`  out  ADDR_W  to memory `direccion`; combinational.
- `mem_data`  in  DATA_W  from memory `instruccion`.
- `if_instr`  out  DATA_W  word for decode; `mem_data` when `if_valid`, else 0.
- `if_pc`  out  ADDR_W  word address of `if_instr`.
- `if_pc_next`  out  ADDR_W  `if_pc`+1, modulo 2^ADDR_W; branch base.
- `if_valid`  out  1  `if_instr`/`if_pc` meaningful.
- `halted`  out  1  fetch stopped on HLT.
- `fetch_count`  out  32  words accepted by decode; saturating.

## Operation

- Register `cur_addr` holds the address latched by memory on the last edge, so `mem_data` always equals `rom[cur_addr]`. `if_pc` = `cur_addr`.
- Every edge, `cur_addr <= mem_addr`.
- States:
  - FILL: first cycle after reset; memory output stale.
  - RUN.
  - HALTED.
- `mem_addr` selection, highest priority first:
  - `redirect` -> `redirect_addr`, in any state.
  - FILL -> `RESET_ADDR`.
  - HALTED -> `cur_addr`.
  - `stall` -> `cur_addr`; re-read, so output holds.
  - otherwise `cur_addr`+1, wrapping 1023->0.
- State transitions:
  - FILL -> RUN on the next edge, with or without redirect. `stall` is ignored in FILL.
  - RUN -> HALTED when `if_valid`, `mem_data`==`HALT_WORD`, `!stall` and `!redirect`. The HLT word itself is presented valid for exactly one accepted cycle.
  - HALTED -> RUN on `redirect`; a wrong-path HLT is cancelled by an older branch. Otherwise HALTED persists until reset.
- `if_valid` = (state==RUN); 0 in FILL and HALTED. `halted` = (state==HALTED).
- Redirect inserts no fetch bubble: the target word is valid the next cycle. Squashing the wrong-path word already in IF/ID belongs to decode/control.
- `fetch_count` increments on each edge with `if_valid && !stall`, and holds at 32'hFFFFFFFF.
- Simultaneous `stall` and `redirect`: redirect wins, and the stalled word is discarded.

## Timing

- Reset is asynchronous: state=FILL, `cur_addr`=`RESET_ADDR`, `fetch_count`=0 immediately.
- Output values while reset is asserted: `if_valid`=0, `halted`=0, `if_instr`=0, `if_pc`=`RESET_ADDR`, `mem_addr`=`RESET_ADDR`.
- Reset mid-stream drops any in-flight word; no state survives.
- Latency is 1 cycle from `mem_addr` sampled at edge k to the word valid during cycle k+1.
- Sustained throughput: one word per cycle when unstalled.
- Stall holds `if_instr`/`if_pc` stable for every stalled cycle. The word is accepted on the first unstalled edge.
- Redirect asserted in cycle k: the target word is on `if_instr` in cycle k+1.
- After the last edge of HALTED entry, `mem_addr` is constant.

## Structure

- Shared pipeline package holds:
  - `ADDR_W`, `DATA_W`, `HALT_WORD`.
  - State encoding: FILL=2'd0, RUN=2'd1, HALTED=2'd2.
  - Address wrap helper.
- A single module, no sub-modules; the saturating counter stays inline.
- RTL target is about 150 lines.

## Test plan

- **Reset release:** ROM = {0:20420020, 1:20630001, 2:00432006, rest 0}, reset released.
  - FILL cycle: `if_valid`=0.
  - Then `if_pc` 0,1,2 carry those words, valid.
  - Then `if_pc`=3 with word 0 (HLT) is valid once.
  - Then `halted`=1, `mem_addr` held at 4; `fetch_count`=4.
- **Stall:** `stall` high for 2 cycles while `if_pc`=1.
  - `if_instr`=20630001 and `if_pc`=1 for 3 cycles.
  - `if_pc`=2 follows; `fetch_count` counts address 1 once.
- **Redirect:** `redirect`=1, `redirect_addr`=0 while `if_pc`=2 → next cycle `if_pc`=0, `if_instr`=20420020, valid; no bubble.
- **Redirect out of HALTED:** while HALTED, `redirect_addr`=1 → RUN, `if_pc`=1 valid next cycle, `halted`=0.
- **Wrap and conflicts:**
  - Redirect to 1023 with nonzero word there → next `if_pc`=0.
  - `stall` and `redirect` together → target wins.
- **Async reset:** assert `reset` mid-stream between edges → outputs take reset values immediately. After release, fetching restarts at `RESET_ADDR` through FILL.
